psum_acc_relu: RTL and testbench

PSUM_ACC_RELU -- requirements
Module: psum_acc_relu

---
 rtl/psum_acc_relu_if.sv | 19 +
 rtl/psum_acc_relu.sv | 115 +++++++++++
 tb/tb_psum_acc_relu.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/psum_acc_relu_if.sv
// Handshake bundle for psum_acc_relu: partial-sum input stream and result output stream.
interface psum_acc_relu_if;
  logic               psum_valid;
  logic signed [33:0] psum_in;
  logic               psum_ready;
  logic               out_valid;
  logic               out_ready;
  logic signed [15:0] out_data;

  modport master (
    output psum_valid, psum_in, out_ready,
    input  psum_ready, out_valid, out_data
  );

  modport slave (
    input  psum_valid, psum_in, out_ready,
    output psum_ready, out_valid, out_data
  );
endinterface

// File: rtl/psum_acc_relu.sv
// Partial-sum accumulator with optional ReLU, round-half-up requantization and 16-bit saturation.
// Define PSUM_RELU_EN to clamp negative sums to zero (output range 0..32767).
module psum_acc_relu (
  input  logic           clk,
  input  logic           rst,
  input  logic           clear,
  psum_acc_relu_if.slave bus,
  input  logic [1:0]     acc_len,
  input  logic [3:0]     shift,
  output logic           busy,
  output logic           ovf
);

  typedef enum logic [1:0] {IDLE, ACC, HOLD} state_t;

  state_t             state, state_nxt;
  logic signed [35:0] acc;
  logic [1:0]         cnt, len_q;
  logic [3:0]         shift_q;

  logic               accept, start, done, sat;
  logic [1:0]         len_eff, cnt_nxt;
  logic [3:0]         sh_eff;
  logic signed [35:0] psum_ext, sum_nxt;
  logic signed [36:0] relu_sum, round_add, rounded, shifted;
  logic signed [15:0] res;

  assign bus.psum_ready = (state != HOLD) || bus.out_ready;
  assign bus.out_valid  = (state == HOLD);

  // A group starts on any accept outside ACC (including back-to-back from HOLD),
  // so the final-sum path uses the live acc_len/shift then and the latched copies otherwise.
  always_comb begin
    accept   = bus.psum_valid && bus.psum_ready;
    start    = accept && (state != ACC);
    len_eff  = start ? ((acc_len == 2'd0) ? 2'd1 : acc_len) : len_q;
    sh_eff   = start ? shift : shift_q;
    psum_ext = {{2{bus.psum_in[33]}}, bus.psum_in};
    sum_nxt  = start ? psum_ext : acc + psum_ext;
    cnt_nxt  = start ? 2'd1 : cnt + 2'd1;
    done     = accept && (cnt_nxt == len_eff);

    relu_sum = {sum_nxt[35], sum_nxt};
`ifdef PSUM_RELU_EN
    if (sum_nxt[35]) relu_sum = '0;
`endif
    round_add = (sh_eff != 4'd0) ? (37'sd1 <<< (sh_eff - 4'd1)) : 37'sd0;
    rounded   = relu_sum + round_add;
    shifted   = rounded >>> sh_eff;

    sat = 1'b0;
    res = shifted[15:0];
    if (shifted > 37'sd32767) begin
      sat = 1'b1;
      res = 16'sd32767;
    end
`ifndef PSUM_RELU_EN
    else if (shifted < -37'sd32768) begin
      sat = 1'b1;
      res = -16'sd32768;
    end
`endif
  end

  always_comb begin
    state_nxt = state;
    busy      = (state != IDLE);
    case (state)
      IDLE, ACC: if (accept) state_nxt = done ? HOLD : ACC;
      HOLD: begin
        if (accept)             state_nxt = done ? HOLD : ACC;
        else if (bus.out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        state <= IDLE;
    else if (clear) state <= IDLE;
    else            state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc          <= '0;
      cnt          <= '0;
      len_q        <= '0;
      shift_q      <= '0;
      bus.out_data <= '0;
      ovf          <= 1'b0;
    end else if (clear) begin
      acc          <= '0;
      cnt          <= '0;
      len_q        <= '0;
      shift_q      <= '0;
      bus.out_data <= '0;
      ovf          <= 1'b0;
    end else begin
      if (accept) begin
        acc <= sum_nxt;
        cnt <= cnt_nxt;
      end
      if (start) begin
        len_q   <= len_eff;
        shift_q <= shift;
      end
      if (done) begin
        bus.out_data <= res;
        if (sat) ovf <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_psum_acc_relu.sv
// Self-checking bench for psum_acc_relu: directed scenarios plus randomized groups against an integer model.
module tb_psum_acc_relu;

  logic       clk = 1'b0;
  logic       rst;
  logic       clear;
  logic [1:0] acc_len;
  logic [3:0] shift;
  logic       busy;
  logic       ovf;
  int         pass_cnt = 0;
  int         total_cnt = 0;

  psum_acc_relu_if bus ();

  psum_acc_relu dut (
    .clk     (clk),
    .rst     (rst),
    .clear   (clear),
    .bus     (bus),
    .acc_len (acc_len),
    .shift   (shift),
    .busy    (busy),
    .ovf     (ovf)
  );

  always #5 clk = ~clk;

  // Requantization reference: plain integer arithmetic on the exact group sum.
  function automatic longint model_result(input longint sum, input int sh, output bit sat);
    longint v, lo;
    v = sum;
`ifdef PSUM_RELU_EN
    if (v < 0) v = 0;
    lo = 0;
`else
    lo = -32768;
`endif
    if (sh > 0) v = v + (longint'(1) << (sh - 1));
    v = v >>> sh;
    sat = (v > 32767) || (v < lo);
    if (v > 32767) v = 32767;
    if (v < lo) v = lo;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input longint p);
    bus.psum_valid = 1'b1;
    bus.psum_in    = p[33:0];
    tick();
    bus.psum_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy got %b exp 0", busy); else pass_cnt++;
    total_cnt++; if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid got %b exp 0", bus.out_valid); else pass_cnt++;
    total_cnt++; if (ovf !== 1'b0) $display("FAIL reset_ovf got %b exp 0", ovf); else pass_cnt++;
    total_cnt++; if (bus.psum_ready !== 1'b1) $display("FAIL reset_psum_ready got %b exp 1", bus.psum_ready); else pass_cnt++;
    total_cnt++; if (bus.out_data !== 16'sd0) $display("FAIL reset_out_data got %0d exp 0", bus.out_data); else pass_cnt++;
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_accumulate();
    acc_len = 2'd3; shift = 4'd0; bus.out_ready = 1'b1;
    push(100);
    total_cnt++; if (bus.out_valid !== 1'b0) $display("FAIL acc_early_valid got %b exp 0", bus.out_valid); else pass_cnt++;
    push(-30);
    push(5);
    total_cnt++; if (bus.out_valid !== 1'b1) $display("FAIL acc_valid got %b exp 1", bus.out_valid); else pass_cnt++;
    total_cnt++; if (bus.out_data !== 16'sd75) $display("FAIL acc_data got %0d exp 75", bus.out_data); else pass_cnt++;
    total_cnt++; if (ovf !== 1'b0) $display("FAIL acc_ovf got %b exp 0", ovf); else pass_cnt++;
    tick();
    total_cnt++; if (bus.out_valid !== 1'b0) $display("FAIL acc_retire_valid got %b exp 0", bus.out_valid); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL acc_retire_busy got %b exp 0", busy); else pass_cnt++;
  endtask

  task automatic test_round();
    logic signed [15:0] exp_neg;
`ifdef PSUM_RELU_EN
    exp_neg = 16'sd0;
`else
    exp_neg = -16'sd1;
`endif
    acc_len = 2'd1; shift = 4'd4;
    push(24);
    total_cnt++; if (bus.out_data !== 16'sd2) $display("FAIL round_pos got %0d exp 2", bus.out_data); else pass_cnt++;
    tick();
    push(-24);
    total_cnt++; if (bus.out_data !== exp_neg) $display("FAIL round_neg got %0d exp %0d", bus.out_data, exp_neg); else pass_cnt++;
    tick();
    acc_len = 2'd0; shift = 4'd0;
    push(-5);
    total_cnt++; if (bus.out_valid !== 1'b1) $display("FAIL len0_valid got %b exp 1", bus.out_valid); else pass_cnt++;
    tick();
  endtask

  task automatic test_saturate();
    acc_len = 2'd2; shift = 4'd0;
    push(40000);
    push(40000);
    total_cnt++; if (bus.out_data !== 16'sd32767) $display("FAIL sat_data got %0d exp 32767", bus.out_data); else pass_cnt++;
    total_cnt++; if (ovf !== 1'b1) $display("FAIL sat_ovf got %b exp 1", ovf); else pass_cnt++;
    tick();
    acc_len = 2'd1;
    push(7);
    total_cnt++; if (bus.out_data !== 16'sd7) $display("FAIL sat_next_data got %0d exp 7", bus.out_data); else pass_cnt++;
    total_cnt++; if (ovf !== 1'b1) $display("FAIL sat_sticky got %b exp 1", ovf); else pass_cnt++;
    tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    total_cnt++; if (ovf !== 1'b0) $display("FAIL clear_ovf got %b exp 0", ovf); else pass_cnt++;
    total_cnt++; if (bus.out_data !== 16'sd0) $display("FAIL clear_data got %0d exp 0", bus.out_data); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    acc_len = 2'd1; shift = 4'd0; bus.out_ready = 1'b0;
    push(11);
    acc_len = 2'd2;
    bus.psum_valid = 1'b1; bus.psum_in = 34'sd55;
    for (int i = 0; i < 5; i++) begin
      total_cnt++; if (bus.psum_ready !== 1'b0) $display("FAIL stall_ready[%0d] got %b exp 0", i, bus.psum_ready); else pass_cnt++;
      tick();
      total_cnt++; if (bus.out_data !== 16'sd11 || bus.out_valid !== 1'b1)
        $display("FAIL stall_data[%0d] got %0d/%b exp 11/1", i, bus.out_data, bus.out_valid); else pass_cnt++;
    end
    bus.out_ready = 1'b1;
    tick();
    total_cnt++; if (bus.out_valid !== 1'b0) $display("FAIL b2b_partial_valid got %b exp 0", bus.out_valid); else pass_cnt++;
    total_cnt++; if (busy !== 1'b1) $display("FAIL b2b_partial_busy got %b exp 1", busy); else pass_cnt++;
    bus.psum_in = 34'sd45;
    tick();
    total_cnt++; if (bus.out_data !== 16'sd100) $display("FAIL b2b_sum got %0d exp 100", bus.out_data); else pass_cnt++;
    acc_len = 2'd1; bus.psum_in = 34'sd9;
    tick();
    total_cnt++; if (bus.out_valid !== 1'b1 || bus.out_data !== 16'sd9)
      $display("FAIL b2b_single got %0d/%b exp 9/1", bus.out_data, bus.out_valid); else pass_cnt++;
    bus.psum_valid = 1'b0;
    tick();
    total_cnt++; if (bus.out_valid !== 1'b0) $display("FAIL b2b_drain got %b exp 0", bus.out_valid); else pass_cnt++;
  endtask

  task automatic test_abort();
    acc_len = 2'd3; shift = 4'd0;
    push(50);
    push(60);
    total_cnt++; if (busy !== 1'b1) $display("FAIL abort_busy_pre got %b exp 1", busy); else pass_cnt++;
    rst = 1'b1;
    #1;
    total_cnt++; if (busy !== 1'b0 || bus.out_valid !== 1'b0)
      $display("FAIL abort_rst got busy=%b valid=%b exp 0/0", busy, bus.out_valid); else pass_cnt++;
    tick();
    rst = 1'b0;
    push(1); push(1); push(1);
    total_cnt++; if (bus.out_data !== 16'sd3) $display("FAIL abort_rst_next got %0d exp 3", bus.out_data); else pass_cnt++;
    tick();
    push(50);
    push(60);
    clear = 1'b1;
    bus.psum_valid = 1'b1; bus.psum_in = 34'sd999;
    tick();
    clear = 1'b0; bus.psum_valid = 1'b0;
    total_cnt++; if (busy !== 1'b0 || bus.out_valid !== 1'b0)
      $display("FAIL abort_clear got busy=%b valid=%b exp 0/0", busy, bus.out_valid); else pass_cnt++;
    push(1); push(1); push(1);
    total_cnt++; if (bus.out_data !== 16'sd3) $display("FAIL abort_clear_next got %0d exp 3", bus.out_data); else pass_cnt++;
    tick();
  endtask

  task automatic test_len_change();
    acc_len = 2'd3; shift = 4'd0;
    push(10);
    acc_len = 2'd1; shift = 4'd5;
    push(20);
    total_cnt++; if (bus.out_valid !== 1'b0) $display("FAIL lenchg_early got %b exp 0", bus.out_valid); else pass_cnt++;
    push(30);
    total_cnt++; if (bus.out_valid !== 1'b1 || bus.out_data !== 16'sd60)
      $display("FAIL lenchg_result got %0d/%b exp 60/1", bus.out_data, bus.out_valid); else pass_cnt++;
    tick();
  endtask

  task automatic test_random();
    logic signed [33:0] r;
    longint sum, p, expv;
    bit sat;
    bit ovf_exp;
    int len, n, sh;
    clear = 1'b1; tick(); clear = 1'b0;
    ovf_exp = 1'b0;
    bus.out_ready = 1'b1;
    for (int g = 0; g < 150; g++) begin
      len = int'($urandom_range(3, 0));
      sh  = int'($urandom_range(15, 0));
      n   = (len == 0) ? 1 : len;
      acc_len = 2'(len); shift = 4'(sh);
      sum = 0;
      for (int i = 0; i < n; i++) begin
        repeat ($urandom_range(2, 0)) tick();
        case ($urandom_range(2, 0))
          0: begin r = 34'({$urandom(), $urandom()}); p = r; end
          1: p = longint'($urandom_range(200000, 0)) - 100000;
          default: p = longint'($urandom_range(4000000, 0)) - 2000000;
        endcase
        push(p);
        sum = sum + p;
        acc_len = 2'($urandom_range(3, 0));
        shift   = 4'($urandom_range(15, 0));
      end
      expv = model_result(sum, sh, sat);
      ovf_exp = ovf_exp | sat;
      total_cnt++; if (bus.out_valid !== 1'b1 || bus.out_data !== expv[15:0])
        $display("FAIL rand_result[%0d] got %0d/%b exp %0d/1 (sum=%0d sh=%0d)", g, bus.out_data, bus.out_valid, expv, sum, sh);
      else pass_cnt++;
      total_cnt++; if (ovf !== ovf_exp) $display("FAIL rand_ovf[%0d] got %b exp %b", g, ovf, ovf_exp); else pass_cnt++;
      bus.out_ready = 1'b0;
      repeat ($urandom_range(3, 0)) tick();
      total_cnt++; if (bus.out_data !== expv[15:0]) $display("FAIL rand_hold[%0d] got %0d exp %0d", g, bus.out_data, expv); else pass_cnt++;
      bus.out_ready = 1'b1;
      tick();
      total_cnt++; if (bus.out_valid !== 1'b0) $display("FAIL rand_retire[%0d] got %b exp 0", g, bus.out_valid); else pass_cnt++;
    end
  endtask

  initial begin
    rst = 1'b0; clear = 1'b0; acc_len = 2'd1; shift = 4'd0;
    bus.psum_valid = 1'b0; bus.psum_in = '0; bus.out_ready = 1'b1;
    test_reset();
    test_accumulate();
    test_round();
    test_saturate();
    test_back_to_back();
    test_abort();
    test_len_change();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got still running exp finished");
    $fatal(1, "timeout");
  end

endmodule
